// File: rtl/nn_fixed_pkg.sv
// Shared Q7.8 fixed-point definitions for the neuron MAC and sigmoid activation stages.
package nn_fixed_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    localparam logic [DATA_W-1:0] Q78_MIN = 16'h8000;
    localparam logic [DATA_W-1:0] Q78_MAX = 16'h7FFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/q78_round_sat.sv
// Wide signed accumulator to signed Q7.8: round half up, then clip to the 16-bit range.
module q78_round_sat #(
    parameter int ACC_W  = 40,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic        [DATA_W-1:0] x,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] HALF =
        {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    logic signed [ACC_W-1:0]      sum_s;
    logic signed [ACC_W-1:0]      rnd_s;
    logic        [ACC_W-DATA_W:0] top_s;

    // Result fits only when every bit above the Q7.8 sign bit is a copy of it
    always_comb begin
        sum_s = acc + HALF;
        rnd_s = sum_s >>> FRAC_W;
        top_s = rnd_s[ACC_W-1:DATA_W-1];
        if ((top_s == {(ACC_W-DATA_W+1){1'b0}}) || (top_s == {(ACC_W-DATA_W+1){1'b1}})) begin
            x   = rnd_s[DATA_W-1:0];
            sat = 1'b0;
        end else if (rnd_s[ACC_W-1]) begin
            x   = {1'b1, {(DATA_W-1){1'b0}}};
            sat = 1'b1;
        end else begin
            x   = {1'b0, {(DATA_W-1){1'b1}}};
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac_q78.sv
// Streaming MAC neuron: multiply/accumulate beats, add bias, round/saturate to Q7.8 with valid/ready.
module neuron_mac_q78 #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [DATA_W-1:0] act,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_x,
    output logic              out_sat,
    output logic [LEN_W-1:0]  out_len
);

    import nn_fixed_pkg::*;

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t                    state_r;
    state_t                    state_nx_s;
    logic [1:0]                drain_cnt_r;
    logic signed [PROD_W-1:0]  prod_r;
    logic                      s1_valid_r;
    logic                      s1_first_r;
    logic [DATA_W-1:0]         bias_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]          prod_ext_s;
    logic [ACC_W-1:0]          bias_ext_s;
    logic [LEN_W-1:0]          beat_cnt_r;
    logic                      accept_s;
    logic                      drain_done_s;
    logic [DATA_W-1:0]         rs_x_s;
    logic                      rs_sat_s;

    assign in_ready     = (state_r == IDLE) || (state_r == ACC);
    assign accept_s     = in_valid && in_ready;
    assign drain_done_s = (state_r == DRAIN) && (drain_cnt_r == 2'd2);
    assign prod_ext_s   = {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};
    // Bias is Q7.8; shifting by FRAC_W aligns it with the Q.16 products
    assign bias_ext_s   = {{(ACC_W-DATA_W-FRAC_W){bias_r[DATA_W-1]}}, bias_r, {FRAC_W{1'b0}}};

    q78_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_round_sat (
        .acc (acc_r),
        .x   (rs_x_s),
        .sat (rs_sat_s)
    );

    // Next-state logic for the vector sequencing FSM
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nx_s = in_last ? DRAIN : ACC;
                else          state_nx_s = IDLE;
            end
            ACC: begin
                if (accept_s && in_last) state_nx_s = DRAIN;
                else                     state_nx_s = ACC;
            end
            DRAIN: begin
                if (drain_done_s) state_nx_s = OUT;
                else              state_nx_s = DRAIN;
            end
            OUT: begin
                if (out_ready) state_nx_s = IDLE;
                else           state_nx_s = OUT;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Datapath pipeline, FSM state and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            drain_cnt_r <= 2'd0;
            prod_r      <= {PROD_W{1'b0}};
            s1_valid_r  <= 1'b0;
            s1_first_r  <= 1'b0;
            bias_r      <= {DATA_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            beat_cnt_r  <= {LEN_W{1'b0}};
            out_valid   <= 1'b0;
            out_x       <= {DATA_W{1'b0}};
            out_sat     <= 1'b0;
            out_len     <= {LEN_W{1'b0}};
        end else begin
            state_r <= state_nx_s;

            if (state_r == DRAIN) drain_cnt_r <= drain_cnt_r + 2'd1;
            else                  drain_cnt_r <= 2'd0;

            if (accept_s) begin
                prod_r     <= $signed(act) * $signed(weight);
                s1_valid_r <= 1'b1;
                s1_first_r <= (state_r == IDLE);
                if (state_r == IDLE) begin
                    bias_r     <= bias;
                    beat_cnt_r <= LEN_ONE;
                end else begin
                    beat_cnt_r <= beat_cnt_r + LEN_ONE;
                end
            end else begin
                s1_valid_r <= 1'b0;
            end

            if (s1_valid_r) begin
                if (s1_first_r) acc_r <= bias_ext_s + prod_ext_s;
                else            acc_r <= acc_r + prod_ext_s;
            end else begin
                acc_r <= acc_r;
            end

            // Result registers load once per vector and hold until consumed
            if (drain_done_s) begin
                out_valid <= 1'b1;
                out_x     <= rs_x_s;
                out_sat   <= rs_sat_s;
                out_len   <= beat_cnt_r;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_q78.sv
// Directed self-checking bench for neuron_mac_q78 with hand-computed Q7.8 results.
module tb_neuron_mac_q78;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] act;
    logic [15:0] weight;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic        out_sat;
    logic [9:0]  out_len;

    int n_checks = 0;
    int n_fail   = 0;

    neuron_mac_q78 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .act       (act),
        .weight    (weight),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_sat   (out_sat),
        .out_len   (out_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sends n identical beats (bias 0xDEAD on non-first beats), waits for the result,
    // checks it, then optionally holds off out_ready for hold cycles before consuming.
    task automatic run_vec(input string tag, input int n, input logic [15:0] a,
                           input logic [15:0] w, input logic [15:0] b, input bit gap,
                           input logic [15:0] ex, input logic es, input logic [9:0] el,
                           input int hold);
        int lat;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            act      = a;
            weight   = w;
            bias     = (i == 0) ? b : 16'hDEAD;
            in_last  = (i == n - 1);
            @(posedge clk); #1;
            if (gap && i == 0 && n > 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, ".latency"}, lat, 3);
        check_eq({tag, ".x"}, {16'h0, out_x}, {16'h0, ex});
        check_eq({tag, ".sat"}, {31'h0, out_sat}, {31'h0, es});
        check_eq({tag, ".len"}, {22'h0, out_len}, {22'h0, el});
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check_eq({tag, ".hold_valid"}, {31'h0, out_valid}, 32'h1);
            check_eq({tag, ".hold_x"}, {16'h0, out_x}, {16'h0, ex});
            check_eq({tag, ".hold_sat"}, {31'h0, out_sat}, {31'h0, es});
            check_eq({tag, ".hold_len"}, {22'h0, out_len}, {22'h0, el});
            check_eq({tag, ".hold_in_ready"}, {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, ".valid_drop"}, {31'h0, out_valid}, 32'h0);
        check_eq({tag, ".in_ready_back"}, {31'h0, in_ready}, 32'h1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, ".valid"}, {31'h0, out_valid}, 32'h0);
        check_eq({tag, ".x"}, {16'h0, out_x}, 32'h0);
        check_eq({tag, ".sat"}, {31'h0, out_sat}, 32'h0);
        check_eq({tag, ".len"}, {22'h0, out_len}, 32'h0);
        check_eq({tag, ".in_ready"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        act       = 16'h0;
        weight    = 16'h0;
        bias      = 16'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        run_vec("single",   1, 16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h0100, 1'b0, 10'd1, 0);
        run_vec("three",    3, 16'h0200, 16'h0080, 16'h0080, 1'b1, 16'h0380, 1'b0, 10'd3, 0);
        run_vec("round_up", 1, 16'h0001, 16'h0080, 16'h0000, 1'b0, 16'h0001, 1'b0, 10'd1, 0);
        run_vec("round_neg",1, 16'h0001, 16'hFF80, 16'h0000, 1'b0, 16'h0000, 1'b0, 10'd1, 0);
        run_vec("sat_pos",  4, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF, 1'b1, 10'd4, 0);
        run_vec("sat_neg",  4, 16'h7FFF, 16'h8000, 16'h0000, 1'b0, 16'h8000, 1'b1, 10'd4, 0);
        run_vec("bias_neg", 2, 16'h0100, 16'h0100, 16'hFE00, 1'b0, 16'h0000, 1'b0, 10'd2, 0);
        run_vec("backpress",2, 16'h0180, 16'h0200, 16'h0040, 1'b0, 16'h0640, 1'b0, 10'd2, 5);

        // Abort a 4-beat vector after two beats
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            act      = 16'h7FFF;
            weight   = 16'h7FFF;
            bias     = 16'h1234;
            in_last  = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;
        check_zero_outputs("mid_reset");
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero_outputs("post_reset_idle");
        run_vec("after_abort", 1, 16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h0100, 1'b0, 10'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
